pcs_rx_decoder: RTL
===================

# pcs_rx_decoder

64b/66b receive decoder for the 100GbE PCS receive path. It takes descrambled 66-bit coded blocks and produces 64-bit data plus 8-bit control in lane-per-byte form. The output format matches the frame generator's `o_tx_data`/`o_tx_ctrl`, so the decoded stream can be compared directly against the generated stream. A Clause 82-style receive state machine enforces legal block sequencing and replaces illegal blocks with error characters.

## Interface
Parameters:
- `LEN_CODED_BLOCK`, 66: coded block width.
- `LEN_RX_DATA`, 64: decoded data width.
- `LEN_RX_CTRL`, 8: decoded control width, one bit per byte lane.

Ports:
- `i_clock`, input, 1: the block's only clock.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_enable`, input, 1: block valid/advance. When low, all state and outputs hold.
- `i_rx_coded`, input, 66: coded block.
  - [65:64] sync header: 2'b01 = data, 2'b10 = control.
  - [63:56] block type field on control blocks.
- `o_rx_data`, output, 64: decoded bytes. Lane i is bits [63-8i -: 8]; lane 0 is first on the wire.
- `o_rx_ctrl`, output, 8: bit [7-i] set means lane i carries a control character.
- `o_decode_err`, output, 1: the current output word is an error substitution.
- `o_error_count`, output, 16: saturating error counter (see Configuration).

## Operation
Every block is classified into exactly one class:
- **D**: sync 01. All 8 lanes are data taken from [63:0]. `ctrl` = 8'h00.
- **C**, type 8'h1E: eight 7-bit control codes in [55:0]; lane i code is at [55-7i -: 7].
  - Code 7'h00 maps to 8'h07 (idle); code 7'h1E maps to 8'hFE (error).
  - Any other code makes the block class E.
  - Output `ctrl` = 8'hFF.
- **C**, type 8'h4B (ordered set):
  - Lane 0 = 8'h9C; lanes 1–3 = [55:32]; lanes 4–7 = 8'h07.
  - `ctrl` = 8'h8F.
  - The O-code in [31:28] must be 4'h0, otherwise the block is class E.
- **S**, type 8'h78:
  - Lane 0 = 8'hFB; lanes 1–7 = [55:0].
  - `ctrl` = 8'h80.
- **T_k**, types 8'h87/99/AA/B4/CC/D2/E1/FF for k = 0..7:
  - Lanes 0..k-1 are data from [55-8i -: 8].
  - Lane k = 8'hFD; lanes k+1..7 = 8'h07.
  - `ctrl` has bits for lanes k..7 set (e.g. T3 gives 8'h1F).
- **E**: any other sync header (00/11), or any other type byte.

State machine. States are INIT, C, D, T, E. The reset state is INIT. The next state is selected by the current block's class:
- INIT, C, T: on C go to C; on S go to D; otherwise go to E.
- D: on D stay in D; on T go to T; otherwise go to E.
- E: on C go to C; on D go to D; on T go to T; on S go to D; otherwise stay in E.

Output rules:
- If the transition's target state is E, the output word is error: data = 64'hFEFE_FEFE_FEFE_FEFE, `ctrl` = 8'hFF, `o_decode_err` = 1.
- Otherwise the decoded word is output and `o_decode_err` = 0.

## Timing
- Latency is 1 cycle: the block accepted at edge n, with `i_enable` = 1, appears on the outputs after edge n.
- No back-pressure. `i_enable` low freezes the state, all outputs, and the counter.
- Reset values:
  - state INIT
  - `o_rx_data` = 64'h0707_0707_0707_0707
  - `o_rx_ctrl` = 8'hFF
  - `o_decode_err` = 0
  - `o_error_count` = 0
- Reset has priority over `i_enable`. Reset asserted mid-packet returns the machine to INIT, and the next D block is therefore flagged as an error.
- All outputs are registered; no combinational path runs from input to output.

## Configuration
- `PCS_RX_DEC_ERRCNT_EN` defined:
  - `o_error_count` increments by 1 on each accepted block with `o_decode_err` = 1.
  - It saturates at 16'hFFFF and is cleared only by `i_reset`.
- Not defined: `o_error_count` is tied to 16'h0000 and no counter flops are instantiated.

## Test plan
- Reset, then send C(all idle), S, D×4, T3, C. Required outputs, in order:
  - 07…07 / FF
  - FB+payload / 80
  - D / 00 ×4
  - 3 data + FD + 07×4 / 1F
  - idle / FF
  - `o_decode_err` never asserted.
- After reset, send D as the first block. Required: error word FE×8 / FF with `o_decode_err` = 1; then C gives idle output.
- While in D, send S. Required: error output, state E. A following D decodes normally and the machine enters D.
- Send a block with sync 2'b00, and separately a type-8'h55 block. Both give error outputs. With the macro defined, `o_error_count` = 2.
- Hold `i_enable` low for 5 cycles mid-packet. Required: outputs frozen; on re-enable, decoding continues with no error.
- Macro defined: feed 70000 consecutive E blocks. Required: `o_error_count` = 16'hFFFF, with no wrap to zero.

Source files
------------

// File: rtl/pcs_rx_decoder.sv
// 64b/66b receive decoder: classifies each coded block, runs the receive sequencing FSM
// and emits registered 64-bit data / 8-bit lane control. Error counter: PCS_RX_DEC_ERRCNT_EN.
module pcs_rx_decoder #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_RX_DATA     = 64,
  parameter int LEN_RX_CTRL     = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [LEN_CODED_BLOCK-1:0] i_rx_coded,
  output logic [LEN_RX_DATA-1:0]     o_rx_data,
  output logic [LEN_RX_CTRL-1:0]     o_rx_ctrl,
  output logic                       o_decode_err,
  output logic [15:0]                o_error_count,
  output logic [2:0]                 o_dbg_state
);

  // Stream contract: no back-pressure; i_enable marks an accepted block, and the
  // decoded word for that block is valid on the outputs after the same clock edge.

  typedef enum logic [2:0] {
    ST_INIT = 3'd0, ST_C = 3'd1, ST_D = 3'd2, ST_T = 3'd3, ST_E = 3'd4
  } state_t;

  typedef enum logic [2:0] {BLK_C, BLK_D, BLK_S, BLK_T, BLK_E} blk_t;

  localparam logic [63:0] IDLE_WORD = {8{8'h07}};
  localparam logic [63:0] ERR_WORD  = {8{8'hFE}};

  logic [1:0]  w_hdr;
  logic [7:0]  w_type;
  logic [55:0] w_body;
  logic [2:0]  w_tk;
  logic        w_is_t;
  logic [6:0]  w_code;
  blk_t        w_class;
  logic [63:0] w_data;
  logic [7:0]  w_ctrl;
  state_t      w_next;
  state_t      r_state;
  logic [63:0] r_data;
  logic [7:0]  r_ctrl;
  logic        r_err;

  assign w_hdr  = i_rx_coded[65:64];
  assign w_type = i_rx_coded[63:56];
  assign w_body = i_rx_coded[55:0];

  always_comb begin
    w_is_t = 1'b1;
    w_tk   = 3'd0;
    case (w_type)
      8'h87:   w_tk = 3'd0;
      8'h99:   w_tk = 3'd1;
      8'hAA:   w_tk = 3'd2;
      8'hB4:   w_tk = 3'd3;
      8'hCC:   w_tk = 3'd4;
      8'hD2:   w_tk = 3'd5;
      8'hE1:   w_tk = 3'd6;
      8'hFF:   w_tk = 3'd7;
      default: w_is_t = 1'b0;
    endcase
  end

  // Lanes default to idle so only the lanes carrying payload need explicit writes.
  always_comb begin
    w_class = BLK_E;
    w_data  = IDLE_WORD;
    w_ctrl  = 8'hFF;
    w_code  = 7'h00;
    if (w_hdr == 2'b01) begin
      w_class = BLK_D;
      w_data  = i_rx_coded[63:0];
      w_ctrl  = 8'h00;
    end else if (w_hdr == 2'b10) begin
      if (w_type == 8'h1E) begin
        w_class = BLK_C;
        for (int i = 0; i < 8; i++) begin
          w_code = w_body[55-7*i -: 7];
          if (w_code == 7'h1E) w_data[63-8*i -: 8] = 8'hFE;
          else if (w_code != 7'h00) w_class = BLK_E;
        end
      end else if (w_type == 8'h4B) begin
        w_class = (w_body[31:28] == 4'h0) ? BLK_C : BLK_E;
        w_data  = {8'h9C, w_body[55:32], {4{8'h07}}};
        w_ctrl  = 8'h8F;
      end else if (w_type == 8'h78) begin
        w_class = BLK_S;
        w_data  = {8'hFB, w_body};
        w_ctrl  = 8'h80;
      end else if (w_is_t) begin
        w_class = BLK_T;
        w_ctrl  = 8'hFF >> w_tk;
        for (int i = 0; i < 7; i++) begin
          if (3'(i) < w_tk) w_data[63-8*i -: 8] = w_body[55-8*i -: 8];
        end
        for (int i = 0; i < 8; i++) begin
          if (3'(i) == w_tk) w_data[63-8*i -: 8] = 8'hFD;
        end
      end
    end
  end

  always_comb begin
    w_next = ST_E;
    case (r_state)
      ST_D: begin
        if (w_class == BLK_D)      w_next = ST_D;
        else if (w_class == BLK_T) w_next = ST_T;
      end
      ST_E: begin
        case (w_class)
          BLK_C:   w_next = ST_C;
          BLK_D:   w_next = ST_D;
          BLK_T:   w_next = ST_T;
          BLK_S:   w_next = ST_D;
          default: w_next = ST_E;
        endcase
      end
      default: begin
        if (w_class == BLK_C)      w_next = ST_C;
        else if (w_class == BLK_S) w_next = ST_D;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_data  <= IDLE_WORD;
      r_ctrl  <= 8'hFF;
      r_err   <= 1'b0;
    end else if (i_enable) begin
      r_state <= w_next;
      if (w_next == ST_E) begin
        r_data <= ERR_WORD;
        r_ctrl <= 8'hFF;
        r_err  <= 1'b1;
      end else begin
        r_data <= w_data;
        r_ctrl <= w_ctrl;
        r_err  <= 1'b0;
      end
    end
  end

`ifdef PCS_RX_DEC_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Saturates rather than wrapping so a long error burst stays visible.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_err_cnt <= 16'h0000;
    end else if (i_enable && (w_next == ST_E) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'h0001;
    end
  end

  assign o_error_count = r_err_cnt;
`else
  assign o_error_count = 16'h0000;
`endif

  assign o_rx_data    = r_data;
  assign o_rx_ctrl    = r_ctrl;
  assign o_decode_err = r_err;
  assign o_dbg_state  = r_state;

endmodule
